// File: rtl/j1_uart_io.sv
// j1_uart_io -- I/O-space responder for the j1 core.
//
// Decodes the core's I/O read/write strobes and provides a byte UART
// (8N1 TX and RX) plus a status register. Firmware uses it as its
// console and loader path.
//
// Ports:
//   clk      system clock
//   resetq   asynchronous, active-low reset
//   io_rd    core I/O read strobe, one cycle per access
//   io_wr    core I/O write strobe, one cycle per access
//   io_addr  16-bit I/O address, valid with either strobe
//   io_dout  write data from the core (only [7:0] is used)
//   io_din   registered read data to the core
//   uart_tx  serial output, idle high
//   uart_rx  serial input, asynchronous to clk
//
// Status word: [0] tx_busy, [1] rx_valid, [2] rx_overrun,
//              [3] rx_frame_err, [6:4] RX FIFO count (0 without FIFO).
//
// Build option: define J1_UART_RX_FIFO_EN to replace the single RX
// holding register with a 4-entry receive FIFO.

module j1_uart_io #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter logic [15:0] DATA_ADDR    = 16'h1000,
    parameter logic [15:0] STAT_ADDR    = 16'h2000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * 2);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic rd_data, rd_stat, wr_data;

    assign rd_data = io_rd && (io_addr == DATA_ADDR);
    assign rd_stat = io_rd && (io_addr == STAT_ADDR);
    assign wr_data = io_wr && (io_addr == DATA_ADDR);

    // Upper byte of write data has no meaning for a byte UART.
    logic unused_dout_hi;
    assign unused_dout_hi = ^io_dout[15:8];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_e      tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             tx_busy_q;
    logic             tx_q;

    // The accepting write only arms tx_busy; START begins on the next
    // edge. Writes outside IDLE-and-not-busy fall through and are lost.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_busy_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                ST_IDLE: begin
                    if (tx_busy_q) begin
                        tx_state_q <= ST_START;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                    end else if (wr_data) begin
                        tx_shift_q <= io_dout[7:0];
                        tx_busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_state_q <= ST_DATA;
                        tx_q       <= tx_shift_q[0];
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= ST_STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_q       <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_state_q <= ST_IDLE;
                        tx_busy_q  <= 1'b0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= ST_IDLE;
            endcase
        end
    end

    assign uart_tx = tx_q;

    // ------------------------------------------------------------------
    // Receiver: 2-flop synchronizer plus edge-detect history
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    uart_state_e      rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= ST_START;
                        rx_cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        rx_state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= ST_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_state_q <= ST_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= ST_IDLE;
            endcase
        end
    end

    logic rx_stop_sample, rx_deliver, rx_ferr_set;

    assign rx_stop_sample = (rx_state_q == ST_STOP) && (rx_cnt_q == BIT_LAST);
    assign rx_deliver     = rx_stop_sample && rx_sync_q;
    assign rx_ferr_set    = rx_stop_sample && !rx_sync_q;

    // ------------------------------------------------------------------
    // Received-byte storage
    // ------------------------------------------------------------------
    logic       rx_valid;
    logic [7:0] rx_head;
    logic [2:0] stat_cnt;
    logic       ovr_set;

`ifdef J1_UART_RX_FIFO_EN
    logic [7:0] rx_fifo_q [4];
    logic [1:0] rx_wr_ptr_q, rx_rd_ptr_q;
    logic [2:0] rx_count_q;
    logic       rx_push, rx_pop;

    assign rx_pop  = rd_data && (rx_count_q != 3'd0);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign rx_push = rx_deliver && ((rx_count_q != 3'd4) || rx_pop);
    assign ovr_set = rx_deliver && (rx_count_q == 3'd4) && !rx_pop;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int unsigned i = 0; i < 4; i++) begin
                rx_fifo_q[i] <= '0;
            end
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            if (rx_push) begin
                rx_fifo_q[rx_wr_ptr_q] <= rx_shift_q;
                rx_wr_ptr_q            <= rx_wr_ptr_q + 2'd1;
            end
            if (rx_pop) begin
                rx_rd_ptr_q <= rx_rd_ptr_q + 2'd1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count_q <= rx_count_q + 3'd1;
                2'b01:   rx_count_q <= rx_count_q - 3'd1;
                default: rx_count_q <= rx_count_q;
            endcase
        end
    end

    assign rx_valid = (rx_count_q != 3'd0);
    assign rx_head  = rx_fifo_q[rx_rd_ptr_q];
    assign stat_cnt = rx_count_q;
`else
    logic [7:0] rx_byte_q;
    logic       rx_valid_q;

    assign ovr_set = rx_deliver && rx_valid_q && !rd_data;

    // A delivery coinciding with a data read replaces the byte being read
    // out, so rx_valid stays set and no overrun is flagged.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_deliver) begin
            if (!rx_valid_q || rd_data) begin
                rx_byte_q <= rx_shift_q;
            end
            rx_valid_q <= 1'b1;
        end else if (rd_data) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_head  = rx_byte_q;
    assign stat_cnt = 3'd0;
`endif

    // ------------------------------------------------------------------
    // Error flags and read-back register
    // ------------------------------------------------------------------
    logic        rx_ovr_q, rx_ferr_q;
    logic [15:0] io_din_q;
    logic [15:0] stat_word;

    assign stat_word = {9'd0, stat_cnt, rx_ferr_q, rx_ovr_q, rx_valid, tx_busy_q};

    // A new error event on the same edge as a status read is kept.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_ovr_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            if (rd_stat) begin
                rx_ovr_q  <= 1'b0;
                rx_ferr_q <= 1'b0;
            end
            if (ovr_set) begin
                rx_ovr_q <= 1'b1;
            end
            if (rx_ferr_set) begin
                rx_ferr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            io_din_q <= '0;
        end else if (io_rd) begin
            if (rd_stat) begin
                io_din_q <= stat_word;
            end else if (rd_data) begin
                io_din_q <= {8'h00, rx_head};
            end else begin
                io_din_q <= '0;
            end
        end
    end

    assign io_din = io_din_q;

endmodule
